// File: rtl/pipe_stage_skid_reg.sv
// Two-entry (main + skid) pipeline register with valid/ready handshake, flush and step gating.
// Optional macro PIPE_TRISTATE_OUT_EN: cs=1 drives Q to Z and hides out_valid for bus sharing.
module pipe_stage_skid_reg #(
    parameter int                  NrOfBits   = 32,
    parameter logic [NrOfBits-1:0] ResetValue = '0,
    parameter logic [NrOfBits-1:0] FlushValue = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                Flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NrOfBits-1:0] D,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NrOfBits-1:0] Q,
    output logic [1:0]          Level,
    input  logic                cs
);

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_ONE   = 2'd1;
    localparam logic [1:0] LVL_FULL  = 2'd2;

    logic [1:0]          level_q, level_d;
    logic [NrOfBits-1:0] main_q, main_d;
    logic [NrOfBits-1:0] skid_q, skid_d;
    logic                in_ready_q, in_ready_d;

    logic step;
    logic out_valid_int;
    logic acc;
    logic pop;

    assign step = ClockEnable & Tick;

`ifdef PIPE_TRISTATE_OUT_EN
    assign out_valid_int = (level_q != LVL_EMPTY) & ~cs;
    assign Q             = cs ? {NrOfBits{1'bz}} : main_q;
`else
    logic unused_cs;
    assign unused_cs     = cs;
    assign out_valid_int = (level_q != LVL_EMPTY);
    assign Q             = main_q;
`endif

    assign acc = step & in_valid & in_ready_q;
    assign pop = step & out_valid_int & out_ready;

    always_comb begin
        level_d = level_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (step && Flush) begin
            // Flush wins over any simultaneous accept or pop.
            level_d = LVL_EMPTY;
            main_d  = FlushValue;
        end else begin
            case (level_q)
                LVL_EMPTY: begin
                    if (acc) begin
                        main_d  = D;
                        level_d = LVL_ONE;
                    end
                end
                LVL_ONE: begin
                    if (acc && pop) begin
                        main_d = D;
                    end else if (acc) begin
                        skid_d  = D;
                        level_d = LVL_FULL;
                    end else if (pop) begin
                        level_d = LVL_EMPTY;
                    end
                end
                LVL_FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        level_d = LVL_ONE;
                    end
                end
                default: level_d = LVL_EMPTY;
            endcase
        end
        in_ready_d = (level_d != LVL_FULL);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            level_q    <= LVL_EMPTY;
            main_q     <= ResetValue;
            skid_q     <= ResetValue;
            in_ready_q <= 1'b1;
        end else begin
            level_q    <= level_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_int;
    assign Level     = level_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_pipe_stage_skid_reg;

    localparam logic [31:0] RST_VAL = 32'h0000_00C3;
    localparam logic [31:0] FL_VAL  = 32'h0000_0013;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ClockEnable = 1'b0;
    logic        Tick = 1'b0;
    logic        Flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] D = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Q;
    logic [1:0]  Level;
    logic        cs = 1'b0;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] mq[$];
    logic [31:0] m_hold = RST_VAL;

    pipe_stage_skid_reg #(
        .NrOfBits(32), .ResetValue(RST_VAL), .FlushValue(FL_VAL)
    ) dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .Flush(Flush), .in_valid(in_valid), .in_ready(in_ready), .D(D),
        .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .Level(Level), .cs(cs)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cs_eff();
`ifdef PIPE_TRISTATE_OUT_EN
        return cs;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_q();
        if (cs_eff()) return 32'hzzzz_zzzz;
        return (mq.size() > 0) ? mq[0] : m_hold;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hold = RST_VAL;
    endtask

    // Behavioural rules: a FIFO of depth 2; ready means "not holding two entries".
    task automatic model_step();
        bit ready, do_pop, do_acc;
        if (!(ClockEnable && Tick)) return;
        if (Flush) begin
            mq.delete();
            m_hold = FL_VAL;
            return;
        end
        ready  = (mq.size() != 2);
        do_pop = (mq.size() > 0) && out_ready && !cs_eff();
        do_acc = in_valid && ready;
        if (do_pop) void'(mq.pop_front());
        if (do_acc) mq.push_back(D);
        if (mq.size() > 0) m_hold = mq[0];
    endtask

    always @(negedge Clock) begin
        if (!Reset) begin
            check("cyc_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0) && !cs_eff()});
            check("cyc_level", {30'd0, Level}, mq.size());
            check("cyc_in_ready", {31'd0, in_ready}, {31'd0, mq.size() != 2});
            check("cyc_q", Q, exp_q());
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                         input logic ce, input logic tk, input logic fl);
        in_valid = v; D = d; out_ready = ordy; ClockEnable = ce; Tick = tk; Flush = fl;
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask

    initial begin
        repeat (2) @(negedge Clock);
        check("rst_level", {30'd0, Level}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_q", Q, RST_VAL);
        #1 Reset = 1'b0;
        @(negedge Clock);

        // Asynchronous reset in the middle of operation
        drive(1, 32'hA5A5_A5A5, 0, 1, 1, 0);
        check("mid_load_level", {30'd0, Level}, 32'd1);
        check("mid_load_q", Q, 32'hA5A5_A5A5);
        in_valid = 0; ClockEnable = 0; Tick = 0;
        @(posedge Clock);
        #2 Reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_level", {30'd0, Level}, 32'd0);
        check("async_rst_q", Q, RST_VAL);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);

        // Streaming with downstream always ready
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 1, 1, 1, 0);
            check("stream_q", Q, i);
            check("stream_level", {30'd0, Level}, 32'd1);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(0, 0, 1, 1, 1, 0);
        check("drain_level", {30'd0, Level}, 32'd0);
        check("drain_q_hold", Q, 32'd4);

        // Backpressure fills the skid entry
        drive(1, 32'h11, 0, 1, 1, 0);
        drive(1, 32'h22, 0, 1, 1, 0);
        check("skid_level", {30'd0, Level}, 32'd2);
        check("skid_in_ready", {31'd0, in_ready}, 32'd0);
        check("skid_q", Q, 32'h11);
        drive(1, 32'hEE, 1, 1, 1, 0);
        check("unskid_q", Q, 32'h22);
        check("unskid_level", {30'd0, Level}, 32'd1);
        drive(0, 0, 1, 1, 1, 0);
        check("unskid_empty", {30'd0, Level}, 32'd0);
        check("unskid_hold", Q, 32'h22);

        // Step gating
        drive(1, 32'h55, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 32'h66, 1, 1, 0, 0);
        drive(1, 32'h66, 1, 0, 1, 0);
        check("gate_level", {30'd0, Level}, 32'd1);
        check("gate_q", Q, 32'h55);
        drive(1, 32'h66, 1, 1, 1, 0);
        check("gate_one_xfer_q", Q, 32'h66);
        check("gate_one_xfer_level", {30'd0, Level}, 32'd1);

        // Flush priority over accept and pop in FULL
        drive(1, 32'h77, 0, 1, 1, 0);
        check("pre_flush_level", {30'd0, Level}, 32'd2);
        drive(1, 32'h33, 1, 1, 1, 1);
        check("flush_level", {30'd0, Level}, 32'd0);
        check("flush_q", Q, FL_VAL);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        drive(0, 0, 1, 1, 1, 0);
        check("flush_dropped", {30'd0, Level}, 32'd0);

        // Flush without step is ignored; flush in ONE
        drive(1, 32'h99, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 0, 1);
        check("flush_nostep_level", {30'd0, Level}, 32'd1);
        check("flush_nostep_q", Q, 32'h99);
        drive(0, 0, 1, 1, 1, 1);
        check("flush_one_level", {30'd0, Level}, 32'd0);
        check("flush_one_q", Q, FL_VAL);

        // Mixed traffic checked against the model only
        for (int i = 0; i < 24; i++)
            drive(i[0] | i[2], 32'h100 + i, (i % 3) != 0, 1, (i % 5) != 4, i == 17);

`ifdef PIPE_TRISTATE_OUT_EN
        drive(0, 0, 1, 1, 1, 1);
        drive(1, 32'hAB, 0, 1, 1, 0);
        cs = 1'b1;
        drive(0, 0, 1, 1, 1, 0);
        check("cs_q_z", Q, 32'hzzzz_zzzz);
        check("cs_out_valid", {31'd0, out_valid}, 32'd0);
        check("cs_retained", {30'd0, Level}, 32'd1);
        cs = 1'b0;
        #1 check("cs_q_restored", Q, 32'hAB);
        drive(0, 0, 1, 1, 1, 0);
        check("cs_pop", {30'd0, Level}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
